// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//   Iterative multiply/divide unit sitting beside the ALU in the execute stage.
//   Executes MULT, MULTU, DIV and DIVU on two WIDTH-bit operands and produces
//   the HI/LO pair consumed by MFHI/MFLO. Multiply is shift-and-add, divide is
//   restoring; both retire one bit per cycle on operand magnitudes, and the
//   sign is applied in a final FIX cycle.
//
//   Optional feature macro: MULTDIV_EARLY_EXIT_EN
//     defined   : a multiply leaves CALC as soon as the remaining multiplier
//                 is zero (|b| = 0 skips CALC altogether); divides unchanged.
//     undefined : every operation that is not a divide-by-zero runs WIDTH
//                 CALC iterations. Results are identical either way.
//
// Ports
//   CLK     in   rising-edge clock
//   RST     in   synchronous active-high reset (highest priority)
//   start   in   request a new operation, sampled only in IDLE
//   md_op   in   00 MULT, 01 MULTU, 10 DIV, 11 DIVU (sampled with start)
//   port_a  in   multiplicand / dividend (sampled with start)
//   port_b  in   multiplier / divisor (sampled with start)
//   flush   in   abort the in-flight operation; drops a start seen in IDLE
//   busy    out  high in every state except IDLE
//   done    out  one-cycle pulse when hi/lo are updated
//   hi      out  product[2*WIDTH-1:WIDTH] or remainder
//   lo      out  product[WIDTH-1:0] or quotient
//   dz_fl   out  divide-by-zero flag of the last completed divide
// -----------------------------------------------------------------------------
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [1:0]       md_op,
  input  logic [WIDTH-1:0] port_a,
  input  logic [WIDTH-1:0] port_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             dz_fl
);

  localparam int DW = 2 * WIDTH;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  // Operand capture and accumulator clear (the load step) happen on the edge
  // that accepts start, so busy spans exactly N CALC cycles plus one FIX cycle.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } state_t;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [DW-1:0] neg_dw(input logic [DW-1:0] v);
    return ~v + {{(DW-1){1'b0}}, 1'b1};
  endfunction

  state_t             state_r;
  logic               is_div_r;
  logic               is_signed_r;
  logic               sign_a_r;
  logic               sign_b_r;
  logic               dz_r;
  logic [WIDTH-1:0]   a_orig_r;
  logic [DW-1:0]      acc_r;      // product, or {rem, quot} for divide
  logic [DW-1:0]      mcand_r;    // shifted multiplicand, or divisor in low half
  logic [WIDTH-1:0]   mplier_r;
  logic [CNT_W-1:0]   cnt_r;

  logic               op_signed_s;
  logic               b_zero_s;
  logic [WIDTH-1:0]   mag_a_s;
  logic [WIDTH-1:0]   mag_b_s;
  logic [DW-1:0]      mul_acc_s;
  logic [DW:0]        div_shift_s;
  logic [WIDTH:0]     div_trial_s;
  logic [DW-1:0]      div_acc_s;
  logic [DW-1:0]      prod_s;
  logic [WIDTH-1:0]   quot_s;
  logic [WIDTH-1:0]   rem_s;
  logic               calc_last_s;
  logic               skip_calc_s;

  assign op_signed_s = ~md_op[0];
  assign b_zero_s    = (port_b == {WIDTH{1'b0}});
  // |0x80000000| stays 0x80000000, which is correct as an unsigned magnitude.
  assign mag_a_s     = (op_signed_s && port_a[WIDTH-1]) ? neg_w(port_a) : port_a;
  assign mag_b_s     = (op_signed_s && port_b[WIDTH-1]) ? neg_w(port_b) : port_b;

`ifdef MULTDIV_EARLY_EXIT_EN
  // Multiply finishes on the step that shifts the last set multiplier bit out.
  assign calc_last_s = is_div_r ? (cnt_r == LAST_ITER)
                                : (mplier_r[WIDTH-1:1] == {(WIDTH-1){1'b0}});
  assign skip_calc_s = b_zero_s;
`else
  assign calc_last_s = (cnt_r == LAST_ITER);
  assign skip_calc_s = md_op[1] & b_zero_s;
`endif

  // One multiply step and one restoring-divide step computed from current state.
  always_comb begin
    mul_acc_s   = acc_r;
    div_acc_s   = acc_r;
    div_shift_s = {acc_r, 1'b0};
    // Remainder is one bit wider than the divisor after the shift; a clear
    // borrow bit means the trial subtraction succeeded.
    div_trial_s = div_shift_s[DW:WIDTH] - {1'b0, mcand_r[WIDTH-1:0]};
    if (mplier_r[0]) begin
      mul_acc_s = acc_r + mcand_r;
    end else begin
      mul_acc_s = acc_r;
    end
    if (!div_trial_s[WIDTH]) begin
      div_acc_s = {div_trial_s[WIDTH-1:0], div_shift_s[WIDTH-1:1], 1'b1};
    end else begin
      div_acc_s = div_shift_s[DW-1:0];
    end
  end

  // Sign correction applied in FIX.
  always_comb begin
    prod_s = acc_r;
    quot_s = acc_r[WIDTH-1:0];
    rem_s  = acc_r[DW-1:WIDTH];
    if (is_signed_r && (sign_a_r ^ sign_b_r)) begin
      prod_s = neg_dw(acc_r);
      quot_s = neg_w(acc_r[WIDTH-1:0]);
    end else begin
      prod_s = acc_r;
      quot_s = acc_r[WIDTH-1:0];
    end
    if (is_signed_r && sign_a_r) begin
      rem_s = neg_w(acc_r[DW-1:WIDTH]);
    end else begin
      rem_s = acc_r[DW-1:WIDTH];
    end
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r     <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      hi          <= {WIDTH{1'b0}};
      lo          <= {WIDTH{1'b0}};
      dz_fl       <= 1'b0;
      is_div_r    <= 1'b0;
      is_signed_r <= 1'b0;
      sign_a_r    <= 1'b0;
      sign_b_r    <= 1'b0;
      dz_r        <= 1'b0;
      a_orig_r    <= {WIDTH{1'b0}};
      acc_r       <= {DW{1'b0}};
      mcand_r     <= {DW{1'b0}};
      mplier_r    <= {WIDTH{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start && !flush) begin
            busy        <= 1'b1;
            is_div_r    <= md_op[1];
            is_signed_r <= op_signed_s;
            sign_a_r    <= port_a[WIDTH-1];
            sign_b_r    <= port_b[WIDTH-1];
            dz_r        <= md_op[1] & b_zero_s;
            a_orig_r    <= port_a;
            cnt_r       <= {CNT_W{1'b0}};
            mplier_r    <= mag_b_s;
            if (md_op[1]) begin
              acc_r   <= {{WIDTH{1'b0}}, mag_a_s};
              mcand_r <= {{WIDTH{1'b0}}, mag_b_s};
            end else begin
              acc_r   <= {DW{1'b0}};
              mcand_r <= {{WIDTH{1'b0}}, mag_a_s};
            end
            state_r <= skip_calc_s ? FIX : CALC;
          end else begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        CALC: begin
          if (flush) begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
            if (is_div_r) begin
              acc_r <= div_acc_s;
            end else begin
              acc_r    <= mul_acc_s;
              mcand_r  <= {mcand_r[DW-2:0], 1'b0};
              mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
            end
            state_r <= calc_last_s ? FIX : CALC;
          end
        end
        FIX: begin
          busy    <= 1'b0;
          state_r <= IDLE;
          if (flush) begin
            done <= 1'b0;
          end else begin
            done <= 1'b1;
            if (!is_div_r) begin
              hi    <= prod_s[DW-1:WIDTH];
              lo    <= prod_s[WIDTH-1:0];
              dz_fl <= dz_fl;
            end else if (dz_r) begin
              hi    <= a_orig_r;
              lo    <= {WIDTH{1'b1}};
              dz_fl <= 1'b1;
            end else begin
              hi    <= rem_s;
              lo    <= quot_s;
              dz_fl <= 1'b0;
            end
          end
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mult_div_unit
//   Directed, table-driven bench for mult_div_unit: a vector table of
//   operations with hand-computed hi/lo/dz_fl, plus hand-written sequences for
//   flush, mid-operation reset, ignored start and back-to-back start.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         start;
  logic [1:0]   md_op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         flush;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         dz_fl;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } vec_t;

  vec_t vecs[13];

  mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .CLK    (clk),
    .RST    (rst),
    .start  (start),
    .md_op  (md_op),
    .port_a (a),
    .port_b (b),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo),
    .dz_fl  (dz_fl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected start-to-done latency in cycles.
  function automatic int exp_lat(input logic [1:0] op, input logic [W-1:0] bv);
`ifdef MULTDIV_EARLY_EXIT_EN
    logic [W-1:0] m;
    int n;
`endif
    if (op[1]) return (bv == 32'h0) ? 2 : 34;
`ifdef MULTDIV_EARLY_EXIT_EN
    m = (!op[0] && bv[31]) ? (~bv + 32'h1) : bv;
    n = 0;
    for (int i = 0; i < W; i++) if (m[i]) n = i + 1;
    return 2 + n;
`else
    return 34;
`endif
  endfunction

  // Called at the negedge where start was raised; returns the cycle offset of
  // done (lat = k means done is high in cycle S+k), or -1 on timeout. A start
  // with junk operands is pulsed in cycle S+restart_at (0 = never).
  task automatic wait_done(input int restart_at, output int lat);
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k == 1) check("busy_after_start", {63'd0, busy}, 64'd1);
      if (done) begin
        lat = k;
        check("busy_in_done_cycle", {63'd0, busy}, 64'd0);
        break;
      end
      start = (k == restart_at);
      if (k == restart_at) begin
        md_op = 2'b01;
        a     = 32'd100;
        b     = 32'd100;
      end
    end
    start = 1'b0;
    if (lat < 0) $display("FAIL wait_done: no done within 100 cycles");
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    @(negedge clk);
    md_op = v.op;
    a     = v.a;
    b     = v.b;
    start = 1'b1;
    wait_done(0, lat);
    check($sformatf("v%0d_latency", idx), 64'(lat), 64'(exp_lat(v.op, v.b)));
    check($sformatf("v%0d_hi", idx), {32'd0, hi}, {32'd0, v.hi});
    check($sformatf("v%0d_lo", idx), {32'd0, lo}, {32'd0, v.lo});
    check($sformatf("v%0d_dz", idx), {63'd0, dz_fl}, {63'd0, v.dz});
    @(negedge clk);
    check($sformatf("v%0d_done_pulse", idx), {63'd0, done}, 64'd0);
    check($sformatf("v%0d_hi_hold", idx), {32'd0, hi}, {32'd0, v.hi});
  endtask

  // Start MULTU 3 * 0x80000005 and raise the abort input in cycle S+10.
  task automatic start_then_abort(input bit use_reset);
    @(negedge clk);
    md_op = 2'b01;
    a     = 32'd3;
    b     = 32'h8000_0005;
    start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 10) begin
        if (use_reset) rst = 1'b1;
        else flush = 1'b1;
      end
    end
    @(negedge clk);
    rst   = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    int  lat;
    bit  seen_done;

    rst   = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    md_op = 2'b00;
    a     = 32'd0;
    b     = 32'd0;

    //           op     a              b              hi             lo             dz
    vecs[0]  = '{2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
    vecs[1]  = '{2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0};
    vecs[2]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3]  = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
    vecs[4]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[5]  = '{2'b11, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1};
    vecs[6]  = '{2'b01, 32'd5,         32'd3,         32'd0,         32'd15,        1'b1};
    vecs[7]  = '{2'b01, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[8]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
    vecs[9]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b1};
    vecs[10] = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
    vecs[11] = '{2'b00, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[12] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_busy",  {63'd0, busy},  64'd0);
    check("reset_done",  {63'd0, done},  64'd0);
    check("reset_hi",    {32'd0, hi},    64'd0);
    check("reset_lo",    {32'd0, lo},    64'd0);
    check("reset_dz",    {63'd0, dz_fl}, 64'd0);

    for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

    // start together with flush in IDLE is dropped.
    @(negedge clk);
    md_op = 2'b01;
    a     = 32'd3;
    b     = 32'd5;
    start = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    check("idle_flush_busy", {63'd0, busy}, 64'd0);
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    check("idle_flush_no_done", {63'd0, seen_done}, 64'd0);

    // Flush mid-operation: IDLE next cycle, no done, results untouched.
    start_then_abort(1'b0);
    check("flush_busy", {63'd0, busy}, 64'd0);
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    check("flush_no_done", {63'd0, seen_done}, 64'd0);
    check("flush_hi_kept", {32'd0, hi}, 64'h0000_0000_FFFF_FFFE);
    check("flush_lo_kept", {32'd0, lo}, 64'h0000_0000_0000_0001);
    check("flush_dz_kept", {63'd0, dz_fl}, 64'd0);

    // Start pulsed at S+5 is ignored; start in the done cycle is accepted.
    @(negedge clk);
    md_op = 2'b01;
    a     = 32'd3;
    b     = 32'h8000_0005;
    start = 1'b1;
    wait_done(5, lat);
    check("ignore_latency", 64'(lat), 64'd34);
    check("ignore_hi", {32'd0, hi}, 64'h0000_0000_0000_0001);
    check("ignore_lo", {32'd0, lo}, 64'h0000_0000_8000_000F);
    md_op = 2'b11;
    a     = 32'd100;
    b     = 32'd7;
    start = 1'b1;
    wait_done(0, lat);
    check("b2b_latency", 64'(lat), 64'd34);
    check("b2b_hi", {32'd0, hi}, 64'd2);
    check("b2b_lo", {32'd0, lo}, 64'd14);

    // Set dz_fl, then reset mid-operation clears everything.
    run_vec(vecs[5], 105);
    start_then_abort(1'b1);
    check("rst_busy", {63'd0, busy},  64'd0);
    check("rst_done", {63'd0, done},  64'd0);
    check("rst_hi",   {32'd0, hi},    64'd0);
    check("rst_lo",   {32'd0, lo},    64'd0);
    check("rst_dz",   {63'd0, dz_fl}, 64'd0);
    run_vec(vecs[3], 103);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
